cache_bus_arbiter: RTL

- Shares the single memory-side bus between the L1 instruction cache (port I) and the L1 data cache (port D).
- Grants one requester at a time with round-robin fairness and forwards its request downstream.
- Routes the returning block back to the owner of the request.
- Allows exactly one outstanding memory transaction; sits between the two L1 caches and the memory/L2 interface.

---
 rtl/cache_arb_pkg.sv | 8 +
 rtl/cache_bus_arbiter_rr_arb2.sv | 9 +
 rtl/cache_bus_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared types and default widths for the cache bus arbiter.
package cache_arb_pkg;
    localparam int ADDR_W_DEF = 64;
    localparam int TAG_W_DEF  = 13;
    localparam int DATA_W_DEF = 512;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DELIVER} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/cache_bus_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; a tie goes to the port that did not win last.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_d_i,
    output logic [1:0] gnt_o
);
    assign gnt_o[0] = req_i[0] & (~req_i[1] | last_d_i);
    assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_d_i);
endmodule

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: shares one memory bus between the L1 I and D caches, one transaction in flight.
// Define CACHE_ARB_PERF_EN to add per-port grant and wait counters.
module cache_bus_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_reqcyc,
    input  logic [ADDR_W-1:0] i_req,
    input  logic [TAG_W-1:0]  i_reqtag,
    output logic              i_reqack,
    output logic              i_respcyc,
    output logic [DATA_W-1:0] i_resp,
    output logic [TAG_W-1:0]  i_resptag,
    input  logic              i_respack,
    input  logic              d_reqcyc,
    input  logic [ADDR_W-1:0] d_req,
    input  logic [TAG_W-1:0]  d_reqtag,
    output logic              d_reqack,
    output logic              d_respcyc,
    output logic [DATA_W-1:0] d_resp,
    output logic [TAG_W-1:0]  d_resptag,
    input  logic              d_respack,
    output logic              m_reqcyc,
    output logic [ADDR_W-1:0] m_req,
    output logic [TAG_W-1:0]  m_reqtag,
    input  logic              m_reqack,
    input  logic              m_respcyc,
    input  logic [DATA_W-1:0] m_resp,
    input  logic [TAG_W-1:0]  m_resptag,
    output logic              m_respack
`ifdef CACHE_ARB_PERF_EN
    ,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_i_wait,
    output logic [31:0]       perf_d_wait
`endif
);
    state_t            state_q, state_d;
    owner_t            owner_q, owner_d, last_q, last_d;
    logic              ack_q, ack_d;
    logic [ADDR_W-1:0] req_q, req_d;
    logic [TAG_W-1:0]  reqtag_q, reqtag_d, resptag_q, resptag_d;
    logic [DATA_W-1:0] resp_q, resp_d;
    logic [1:0]        gnt;
    logic              take, own_respack;

    rr_arb2 u_rr (
        .req_i    ({d_reqcyc, i_reqcyc} & {2{state_q == IDLE}}),
        .last_d_i (last_q == OWN_D),
        .gnt_o    (gnt)
    );

    // The accept pulse occupies the first ISSUE cycle; the downstream request follows it.
    assign m_reqcyc    = state_q == ISSUE && !ack_q;
    assign take        = m_respcyc && (state_q == WAIT_RESP || (m_reqcyc && m_reqack));
    assign own_respack = owner_q == OWN_D ? d_respack : i_respack;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        ack_d     = 1'b0;
        req_d     = req_q;
        reqtag_d  = reqtag_q;
        resp_d    = resp_q;
        resptag_d = resptag_q;
        m_respack = 1'b0;
        if (|gnt) begin
            owner_d  = gnt[1] ? OWN_D : OWN_I;
            last_d   = gnt[1] ? OWN_D : OWN_I;
            req_d    = gnt[1] ? d_req : i_req;
            reqtag_d = gnt[1] ? d_reqtag : i_reqtag;
            ack_d    = 1'b1;
            state_d  = ISSUE;
        end
        if (m_reqcyc && m_reqack) state_d = WAIT_RESP;
        if (take) begin
            resp_d    = m_resp;
            resptag_d = m_resptag;
            m_respack = 1'b1;
            state_d   = DELIVER;
        end
        if (state_q == DELIVER && own_respack) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            last_q    <= OWN_D;
            ack_q     <= 1'b0;
            req_q     <= '0;
            reqtag_q  <= '0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            ack_q     <= ack_d;
            req_q     <= req_d;
            reqtag_q  <= reqtag_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
        end
    end

    assign m_req     = m_reqcyc ? req_q : '0;
    assign m_reqtag  = m_reqcyc ? reqtag_q : '0;
    assign i_reqack  = ack_q && owner_q == OWN_I;
    assign d_reqack  = ack_q && owner_q == OWN_D;
    assign i_respcyc = state_q == DELIVER && owner_q == OWN_I;
    assign d_respcyc = state_q == DELIVER && owner_q == OWN_D;
    assign i_resp    = i_respcyc ? resp_q : '0;
    assign i_resptag = i_respcyc ? resptag_q : '0;
    assign d_resp    = d_respcyc ? resp_q : '0;
    assign d_resptag = d_respcyc ? resptag_q : '0;

`ifdef CACHE_ARB_PERF_EN
    logic [31:0] gi_q, gd_q, wi_q, wd_q;
    // A requesting port waits in every cycle it is not the one being granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            gi_q <= '0;
            gd_q <= '0;
            wi_q <= '0;
            wd_q <= '0;
        end else begin
            gi_q <= gi_q + 32'(gnt[0]);
            gd_q <= gd_q + 32'(gnt[1]);
            wi_q <= wi_q + 32'(i_reqcyc && !gnt[0]);
            wd_q <= wd_q + 32'(d_reqcyc && !gnt[1]);
        end
    end
    assign perf_i_grants = gi_q;
    assign perf_d_grants = gd_q;
    assign perf_i_wait   = wi_q;
    assign perf_d_wait   = wd_q;
`endif
endmodule
